vga_rectfill: RTL and testbench
===============================

Name: vga_rectfill

Overview:
- Rectangle-fill engine upstream of the VGA controller's VRAM write port (clk domain).
- CPU programs origin, size and 12-bit colour over the local bus, then writes START.
- Block emits one VRAM pixel write per granted cycle into the 640x480 linear frame buffer.
- Offloads large clears and fills from the core; a bus arbiter merges its write stream with CPU VRAM writes.

Parameters:
- XLEN, 32, local bus data/address width (from core_general.vh).
- H_PIXELS, 640, frame width in pixels.
- V_PIXELS, 480, frame height in pixels.
- VADDR_W, 19, VRAM address width.

Ports:
- clk  in  1  global clock; all logic on rising edge
- rst_n  in  1  global reset, asynchronous, active-low
- sel  in  1  register block select
- addr  in  XLEN  byte address; bits [3:2] select the register
- we  in  3  write enable; any nonzero value is a full-word write
- qin  in  XLEN  write data
- qout  out  XLEN  read data
- vblank  in  1  vertical blank from the VGA controller
- vram_req  out  1  pixel write request
- vram_gnt  in  1  arbiter grant; transfer occurs when vram_req and vram_gnt are both high
- vram_addr  out  VADDR_W  pixel address y*640+x
- vram_wdata  out  12  pixel colour {R,G,B}
- done_irq  out  1  one-cycle pulse when a fill completes

Behaviour:
- Registers (addr[3:2]):
  - 0 CTRL: write bit0=1 -> START. Read returns bit0 BUSY, bit1 DONE (sticky). Writing bit1=1 clears DONE.
  - 1 ORIGIN: [9:0] X0, [24:16] Y0.
  - 2 SIZE: [9:0] W, [24:16] H.
  - 3 COLOR: [11:0].
- Register reset values: all 0.
- Register writes to ORIGIN, SIZE and COLOR while BUSY are ignored.
- Read timing: qout is registered, valid one cycle after a read (sel & we==0). Unused bits read 0. qout=0 in cycles following a non-selected access.
- Output reset values: vram_req=0, vram_addr=0, vram_wdata=0, done_irq=0, qout=0, state=IDLE.
- IDLE:
  - START -> SETUP. BUSY=1 from the cycle after the START write.
  - START while BUSY is ignored.
- SETUP (1 cycle):
  - Clip: Wc = min(W, H_PIXELS-X0), Hc = min(H, V_PIXELS-Y0).
  - If X0>=H_PIXELS, Y0>=V_PIXELS, Wc==0 or Hc==0 -> DONE directly; no writes issued.
  - Row base = Y0*640+X0, computed as (Y0<<9)+(Y0<<7)+X0. No multiplier.
  - Otherwise -> FILL.
- FILL:
  - vram_req=1; vram_addr and vram_wdata are stable while the request is not granted.
  - On grant: advance column and address by 1.
  - At the last column: row base += 640, column reset to 0, row += 1.
  - At the last pixel: -> DONE, and vram_req drops in the next cycle.
  - Back-to-back grants give 1 pixel/cycle. Total writes = Wc*Hc.
- DONE (1 cycle): done_irq=1, DONE flag set, BUSY cleared, -> IDLE.
- Reset mid-fill: immediate abort, all state to reset values, no further requests.
- Widths: all address arithmetic is VADDR_W bits, unsigned, no wrap; the maximum address is 307199.

Optional Feature:
- Macro: VGA_RECTFILL_VBLANK_SYNC_EN.
- Defined: SETUP moves to WAIT_VB instead of FILL. WAIT_VB waits for a vblank rising edge (registered edge detect) and then enters FILL. This gives tear-free fills. A clipped/empty fill still goes straight to DONE.
- Undefined: the vblank input is ignored and FILL starts immediately after SETUP.

Decomposition:
- Shared package vga_pkg.vh holds:
  - H_PIXELS and V_PIXELS
  - register offsets (CTRL/ORIGIN/SIZE/COLOR)
  - CTRL bit positions
  - state encodings (IDLE, SETUP, WAIT_VB, FILL, DONE)
- Sub-module reg_rectfill: bus register file, qout register and START/DONE-clear strobes.
- The FSM and address generator stay in vga_rectfill.

Test Plan:
- ORIGIN=(10,20), SIZE=(4,2), COLOR=0xF0A, START, gnt tied 1 -> 8 writes at 12810..12813, 13450..13453, data 0xF0A, 1 pixel/cycle, then done_irq pulses once and CTRL reads 0b10.
- Same fill with gnt toggling 1,0,0,1... -> addr/data held steady while gnt=0; exactly 8 transfers; sequence unchanged.
- ORIGIN=(638,479), SIZE=(10,10) -> clipped to 2x1: writes at 307198 and 307199 only.
- ORIGIN=(700,0) or SIZE=(0,5) -> no vram_req; done_irq two cycles after START.
- START during a fill and SIZE write during a fill -> ignored; the original fill count is preserved. rst_n asserted mid-fill -> vram_req=0 asynchronously, CTRL reads 0.
- With VGA_RECTFILL_VBLANK_SYNC_EN: START with vblank=0 -> no request until vblank rises; the first request comes one cycle after the edge is detected.

Source files
------------

// File: rtl/vga_rectfill_pkg.sv
// Shared definitions for the rectangle-fill engine: frame geometry, register map, CTRL bits, FSM states.
// Build option VGA_RECTFILL_VBLANK_SYNC_EN (see vga_rectfill.sv) makes use of ST_WAIT_VB.
package vga_rectfill_pkg;

    localparam int H_PIXELS = 640;
    localparam int V_PIXELS = 480;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ORIGIN = 2'd1;
    localparam logic [1:0] REG_SIZE   = 2'd2;
    localparam logic [1:0] REG_COLOR  = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WAIT_VB = 3'd2,
        ST_FILL    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef struct packed {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [9:0]  w;
        logic [8:0]  h;
        logic [11:0] color;
    } rect_cfg_t;

endpackage

// File: rtl/vga_rectfill_reg.sv
// Local-bus register file for the fill engine: ORIGIN/SIZE/COLOR, sticky DONE, START strobe.
// Reads return on qout one cycle after the access; geometry writes are dropped while busy.
module vga_rectfill_reg
    import vga_rectfill_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sel_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [2:0]      we_i,
    input  logic [XLEN-1:0] qin_i,
    input  logic            busy_i,
    input  logic            done_set_i,
    output logic [XLEN-1:0] qout_o,
    output rect_cfg_t       cfg_o,
    output logic            start_o
);

    rect_cfg_t       cfg_q, cfg_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] qout_q, qout_d;
    logic            wr, rd;
    logic [1:0]      idx;

    assign wr  = sel_i && (we_i != 3'b000);
    assign rd  = sel_i && (we_i == 3'b000);
    assign idx = addr_i[3:2];

    always_comb begin
        cfg_d   = cfg_q;
        done_d  = done_q;
        qout_d  = '0;
        start_o = 1'b0;

        if (wr) begin
            case (idx)
                REG_CTRL: begin
                    start_o = qin_i[CTRL_START_BIT] && !busy_i;
                    if (qin_i[CTRL_DONE_BIT]) done_d = 1'b0;
                end
                REG_ORIGIN: if (!busy_i) begin
                    cfg_d.x0 = qin_i[9:0];
                    cfg_d.y0 = qin_i[24:16];
                end
                REG_SIZE: if (!busy_i) begin
                    cfg_d.w = qin_i[9:0];
                    cfg_d.h = qin_i[24:16];
                end
                default: if (!busy_i) cfg_d.color = qin_i[11:0];
            endcase
        end

        // A completing fill wins over a simultaneous software clear.
        if (done_set_i) done_d = 1'b1;

        if (rd) begin
            case (idx)
                REG_CTRL: begin
                    qout_d[CTRL_BUSY_BIT] = busy_i;
                    qout_d[CTRL_DONE_BIT] = done_q;
                end
                REG_ORIGIN: begin
                    qout_d[9:0]   = cfg_q.x0;
                    qout_d[24:16] = cfg_q.y0;
                end
                REG_SIZE: begin
                    qout_d[9:0]   = cfg_q.w;
                    qout_d[24:16] = cfg_q.h;
                end
                default: qout_d[11:0] = cfg_q.color;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= '0;
            done_q <= 1'b0;
            qout_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            done_q <= done_d;
            qout_q <= qout_d;
        end
    end

    assign qout_o = qout_q;
    assign cfg_o  = cfg_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i[XLEN-1:4], addr_i[1:0], qin_i[XLEN-1:25], qin_i[15:12]};

endmodule

// File: rtl/vga_rectfill.sv
// Rectangle-fill engine: clips the programmed rectangle to 640x480, then streams one VRAM write per grant.
// Build option VGA_RECTFILL_VBLANK_SYNC_EN: hold the fill until a vblank rising edge (tear-free).
module vga_rectfill
    import vga_rectfill_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int VADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic [XLEN-1:0]    addr,
    input  logic [2:0]         we,
    input  logic [XLEN-1:0]    qin,
    output logic [XLEN-1:0]    qout,
    input  logic               vblank,
    output logic               vram_req,
    input  logic               vram_gnt,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [11:0]        vram_wdata,
    output logic               done_irq
);

    rect_cfg_t cfg;
    logic      start;

    state_e             state_q, state_d;
    logic [VADDR_W-1:0] addr_q, addr_d;
    logic [VADDR_W-1:0] base_q, base_d;
    logic [9:0]         col_q, col_d;
    logic [8:0]         row_q, row_d;
    logic [9:0]         wc_q, wc_d;
    logic [8:0]         hc_q, hc_d;

    vga_rectfill_reg #(.XLEN(XLEN)) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_i      (sel),
        .addr_i     (addr),
        .we_i       (we),
        .qin_i      (qin),
        .busy_i     (state_q != ST_IDLE),
        .done_set_i (state_q == ST_DONE),
        .qout_o     (qout),
        .cfg_o      (cfg),
        .start_o    (start)
    );

    // Clipping; the room terms only matter when the origin is on-screen, so no underflow reaches the FSM.
    logic               x_in, y_in, empty;
    logic [9:0]         w_room, wc;
    logic [8:0]         h_room, hc;
    logic [VADDR_W-1:0] base;

    always_comb begin
        x_in   = cfg.x0 < 10'(H_PIXELS);
        y_in   = cfg.y0 < 9'(V_PIXELS);
        w_room = 10'(H_PIXELS) - cfg.x0;
        h_room = 9'(V_PIXELS) - cfg.y0;
        wc     = (cfg.w < w_room) ? cfg.w : w_room;
        hc     = (cfg.h < h_room) ? cfg.h : h_room;
        empty  = !x_in || !y_in || (wc == 10'd0) || (hc == 9'd0);
        base   = (VADDR_W'(cfg.y0) << 9) + (VADDR_W'(cfg.y0) << 7) + VADDR_W'(cfg.x0);
    end

`ifdef VGA_RECTFILL_VBLANK_SYNC_EN
    logic vb_q, vb_rise;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vb_q <= 1'b0;
        else        vb_q <= vblank;
    end
    assign vb_rise = vblank && !vb_q;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        col_d   = col_q;
        row_d   = row_q;
        wc_d    = wc_q;
        hc_d    = hc_q;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_SETUP;
            ST_SETUP: begin
                if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    wc_d   = wc;
                    hc_d   = hc;
                    base_d = base;
                    addr_d = base;
                    col_d  = '0;
                    row_d  = '0;
`ifdef VGA_RECTFILL_VBLANK_SYNC_EN
                    state_d = ST_WAIT_VB;
`else
                    state_d = ST_FILL;
`endif
                end
            end
`ifdef VGA_RECTFILL_VBLANK_SYNC_EN
            ST_WAIT_VB: if (vb_rise) state_d = ST_FILL;
`endif
            ST_FILL: if (vram_gnt) begin
                if (col_q == wc_q - 10'd1) begin
                    if (row_q == hc_q - 9'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        base_d = base_q + VADDR_W'(H_PIXELS);
                        addr_d = base_q + VADDR_W'(H_PIXELS);
                        col_d  = '0;
                        row_d  = row_q + 9'd1;
                    end
                end else begin
                    col_d  = col_q + 10'd1;
                    addr_d = addr_q + VADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wc_q    <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wc_q    <= wc_d;
            hc_q    <= hc_d;
        end
    end

    assign vram_req   = (state_q == ST_FILL);
    assign vram_addr  = addr_q;
    assign vram_wdata = cfg.color;
    assign done_irq   = (state_q == ST_DONE);

endmodule

// File: tb/tb_vga_rectfill.sv
// Directed bench for vga_rectfill (default build): fills, grant stalls, clipping, empty fills, busy lockout, reset abort.
module tb_vga_rectfill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  we = '0;
    logic [31:0] qin = '0;
    logic [31:0] qout;
    logic        vblank = 1'b0;
    logic        vram_req;
    logic        vram_gnt = 1'b0;
    logic [18:0] vram_addr;
    logic [11:0] vram_wdata;
    logic        done_irq;

    int total = 0;
    int bad = 0;

    logic [18:0] xaddr[$];
    logic [11:0] xdata[$];
    int first_req_c, done_c, done_cnt, extra_req;

    vga_rectfill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .addr       (addr),
        .we         (we),
        .qin        (qin),
        .qout       (qout),
        .vblank     (vblank),
        .vram_req   (vram_req),
        .vram_gnt   (vram_gnt),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .done_irq   (done_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 3'b111; addr = {28'd0, a}; qin = d;
        @(posedge clk);
        #1 sel = 1'b0; we = 3'b000;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 3'b000; addr = {28'd0, a};
        @(posedge clk);
        #1 sel = 1'b0;
        @(negedge clk);
        d = qout;
    endtask

    // mode 0: grant always; mode 1: grant on cycles 2,5,8,...
    task automatic run_fill(input int mode, input int budget);
        logic [18:0] paddr;
        logic [11:0] pdata;
        logic        pend;
        xaddr.delete(); xdata.delete();
        first_req_c = -1; done_c = -1; done_cnt = 0; extra_req = 0; pend = 1'b0;
        paddr = '0; pdata = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            vram_gnt = (mode == 0) ? 1'b1 : ((c % 3) == 2);
            if (vram_req && first_req_c < 0) first_req_c = c;
            if (pend) begin
                chk("hold_addr", 32'(vram_addr), 32'(paddr));
                chk("hold_data", 32'(vram_wdata), 32'(pdata));
            end
            pend  = vram_req && !vram_gnt;
            paddr = vram_addr;
            pdata = vram_wdata;
            if (vram_req && vram_gnt) begin
                xaddr.push_back(vram_addr);
                xdata.push_back(vram_wdata);
            end
            if (done_c >= 0 && vram_req) extra_req++;
            if (done_irq) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
        end
        if (done_c < 0) begin
            total++; bad++;
            $error("FAIL fill_timeout: got no done_irq expected one within %0d cycles", budget);
        end
    endtask

    task automatic chk_xfers(input string tag, input logic [18:0] base0, input logic [18:0] base1,
                             input logic [11:0] col);
        chk({tag, "_count"}, 32'(xaddr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < xaddr.size()) begin
                chk({tag, "_addr"}, 32'(xaddr[i]), 32'((i < 4) ? base0 + 19'(i) : base1 + 19'(i - 4)));
                chk({tag, "_data"}, 32'(xdata[i]), 32'(col));
            end
        end
    endtask

    initial begin
        logic [31:0] d;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(vram_req), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_wdata", 32'(vram_wdata), 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        chk("rst_qout", qout, 32'd0);
        rst_n = 1'b1;
        rd(4'h0, d); chk("rst_ctrl", d, 32'd0);
        rd(4'h8, d); chk("rst_size", d, 32'd0);

        // basic 4x2 fill, full-rate grants
        wr(4'h4, 32'h0014_000A);
        wr(4'h8, 32'h0002_0004);
        wr(4'hC, 32'h0000_0F0A);
        rd(4'hC, d); chk("color_rb", d, 32'h0000_0F0A);
        rd(4'h4, d); chk("origin_rb", d, 32'h0014_000A);
        wr(4'h0, 32'h1);
        run_fill(0, 60);
        chk_xfers("fill1", 19'd12810, 19'd13450, 12'hF0A);
        chk("fill1_first_req", 32'(first_req_c), 32'd2);
        chk("fill1_done_c", 32'(done_c), 32'd10);
        chk("fill1_done_cnt", 32'(done_cnt), 32'd1);
        chk("fill1_extra_req", 32'(extra_req), 32'd0);
        rd(4'h0, d); chk("fill1_ctrl", d, 32'd2);

        // same fill with stalled grants
        wr(4'h0, 32'h1);
        run_fill(1, 80);
        chk_xfers("fill2", 19'd12810, 19'd13450, 12'hF0A);
        chk("fill2_done_c", 32'(done_c), 32'd24);
        chk("fill2_done_cnt", 32'(done_cnt), 32'd1);

        // clipped at bottom-right corner
        wr(4'h4, 32'h01DF_027E);
        wr(4'h8, 32'h000A_000A);
        wr(4'h0, 32'h1);
        run_fill(0, 40);
        chk("clip_count", 32'(xaddr.size()), 32'd2);
        if (xaddr.size() == 2) begin
            chk("clip_addr0", 32'(xaddr[0]), 32'd307198);
            chk("clip_addr1", 32'(xaddr[1]), 32'd307199);
        end
        chk("clip_done_c", 32'(done_c), 32'd4);

        // off-screen origin and zero width: no requests, done two cycles after START
        wr(4'h4, 32'h0000_02BC);
        wr(4'h8, 32'h0002_0004);
        wr(4'h0, 32'h1);
        run_fill(0, 20);
        chk("offscr_count", 32'(xaddr.size()), 32'd0);
        chk("offscr_first_req", first_req_c, 32'hFFFF_FFFF);
        chk("offscr_done_c", 32'(done_c), 32'd2);
        wr(4'h4, 32'h0000_0000);
        wr(4'h8, 32'h0005_0000);
        wr(4'h0, 32'h1);
        run_fill(0, 20);
        chk("zerow_count", 32'(xaddr.size()), 32'd0);
        chk("zerow_done_c", 32'(done_c), 32'd2);

        // DONE clear
        wr(4'h0, 32'h2);
        rd(4'h0, d); chk("done_clr", d, 32'd0);

        // START and geometry writes while busy are ignored
        vram_gnt = 1'b0;
        wr(4'h4, 32'h0014_000A);
        wr(4'h8, 32'h0002_0004);
        wr(4'hC, 32'h0000_00F0);
        wr(4'h0, 32'h1);
        wr(4'h8, 32'h0001_0001);
        wr(4'h0, 32'h1);
        wr(4'hC, 32'h0000_0123);
        rd(4'h0, d); chk("busy_ctrl", d, 32'd1);
        rd(4'h8, d); chk("busy_size", d, 32'h0002_0004);
        chk("busy_req_held", 32'(vram_req), 32'd1);
        chk("busy_addr_held", 32'(vram_addr), 32'd12810);
        run_fill(0, 40);
        chk_xfers("busy", 19'd12810, 19'd13450, 12'h0F0);
        chk("busy_done_c", 32'(done_c), 32'd9);

        // reset during a fill
        wr(4'h4, 32'h0000_0000);
        wr(4'h8, 32'h0001_0064);
        wr(4'h0, 32'h1);
        repeat (10) @(negedge clk);
        chk("mid_req_before", 32'(vram_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_async", 32'(vram_req), 32'd0);
        chk("mid_addr_async", 32'(vram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vram_gnt = 1'b0;
        rd(4'h0, d); chk("mid_ctrl", d, 32'd0);
        rd(4'h8, d); chk("mid_size", d, 32'd0);
        chk("mid_req_after", 32'(vram_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
